divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a new divide; sampled only in IDLE.
REQ-004 SHALL have port signed_div, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-005 SHALL have port a, input, 32 bits: dividend; sampled with start.
REQ-006 SHALL have port b, input, 32 bits: divisor; sampled with start.
REQ-007 SHALL have port annul, input, 1 bit: pipeline flush; cancels the operation in flight.
REQ-008 SHALL have port stall, output, 1 bit: busy; holds the pipeline front end.
REQ-009 SHALL have port ready, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port hi, output, 32 bits: remainder, feeds the HI/LO register hi input.
REQ-011 SHALL have port lo, output, 32 bits: quotient, feeds the HI/LO register lo input.
REQ-012 SHALL have port hilo_we, output, 2 bits: HI/LO write enable; 2'b11 when ready=1, otherwise 2'b00.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 and annul=0, SHALL latch a, b and signed_div and enter RUN; call this edge cycle 0.
REQ-015 SHALL use radix-2 restoring division on operand magnitudes, producing one quotient bit per RUN cycle, for exactly 32 RUN cycles (cycles 1..32).
REQ-016 SHALL enter DONE after the 32nd RUN cycle, assert ready and hilo_we=2'b11 for exactly cycle 33, then return to IDLE.
REQ-017 stall SHALL be 1 combinationally when in IDLE with start=1 and annul=0, and 1 throughout RUN; stall SHALL be 0 in DONE and in IDLE otherwise.
REQ-018 Signed mode: quotient negated iff the operand signs differ; remainder takes the sign of the dividend; all arithmetic modulo 2^32.
REQ-019 0x80000000 / 0xFFFFFFFF (signed) SHALL yield lo=0x80000000, hi=0x00000000, with no trap.
REQ-020 b=0, either mode: SHALL keep the full 33-cycle latency and yield lo=0xFFFFFFFF, hi=a as latched.
REQ-021 hi and lo SHALL update only on entry to DONE and hold their values until the next DONE.
REQ-022 start while in RUN or DONE SHALL be ignored; no queuing.
REQ-023 annul in RUN SHALL return the FSM to IDLE on the next edge, with no ready and with hi/lo unchanged.
REQ-024 annul in DONE SHALL NOT suppress ready; the result has already retired.
REQ-025 annul and start together in IDLE: annul SHALL win; no operation starts and stall=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, clear the iteration counter, and set hi=0, lo=0, ready=0, hilo_we=2'b00, stall=0.
REQ-027 rst SHALL take priority over start and annul in every state, including mid-RUN; the operation in flight is discarded with no ready.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (IDLE/RUN/DONE), DIV_CYCLES=32, and the width constant 32.
REQ-029 SHALL be a single module with no sub-modules; the iteration counter SHALL be 6 bits wide and count 0..31.

Verification
REQ-030 Unsigned: start, a=100, b=7 -> ready only in cycle 33; lo=14, hi=2, hilo_we=2'b11 for one cycle.
REQ-031 Signed: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-032 Signed overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 Divide by zero: a=0x12345678, b=0, signed_div=1 -> lo=0xFFFFFFFF, hi=0x12345678 in cycle 33.
REQ-034 annul in cycle 10 -> no ready; stall=0 from cycle 11; hi/lo keep their prior values; a new start then succeeds with 33-cycle latency.
REQ-035 rst in cycle 20 -> all outputs zero from the next cycle; a further start pulse during RUN (REQ-022) -> no effect.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM states, widths,
// iteration count and a conditional two's-complement negate helper.
package divider_pkg;

  localparam int WIDTH      = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic            en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed (DIV) and
// unsigned (DIVU) modes, with annul/flush and a one-cycle HI/LO write pulse.
module divider
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       hilo_we
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifts out as quotient shifts in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               accept;

  assign accept    = (state_q == IDLE) && start && !annul;
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~trial[WIDTH];
  assign rem_step  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {dvd_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          cnt_d     = '0;
          dvd_d     = cond_neg(a, signed_div && a[WIDTH-1]);
          dvs_d     = cond_neg(b, signed_div && b[WIDTH-1]);
          rem_d     = '0;
          neg_quo_d = signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_div && a[WIDTH-1];
          zero_d    = (b == '0);
        end
      end
      RUN: begin
        if (annul) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          dvd_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            // Divide-by-zero forces all-ones quotient regardless of sign;
            // the remainder already reconstructs the latched dividend.
            lo_d    = zero_q ? '1 : cond_neg(quo_step, neg_quo_q);
            hi_d    = cond_neg(rem_step, neg_rem_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stall   = accept || (state_q == RUN);
  assign ready   = (state_q == DONE);
  assign hilo_we = {2{ready}};
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: hand-computed quotients and
// remainders, latency, annul, reset and ignored-start behaviour.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  hilo_we;

  int n_checks = 0;
  int n_fail   = 0;

  divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall      (stall),
    .ready      (ready),
    .hi         (hi),
    .lo         (lo),
    .hilo_we    (hilo_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full divide from IDLE; lands one cycle after the ready pulse.
  task automatic do_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic sg, input logic [31:0] elo, input logic [31:0] ehi,
                        input bit mid_start, input bit annul_done);
    int bad;
    bad = 0;
    a = ta; b = tb_v; signed_div = sg; annul = 1'b0; start = 1'b1;
    #1;
    check({tag, " stall_on_start"}, {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (ready !== 1'b0 || stall !== 1'b1 || hilo_we !== 2'b00) bad++;
      if (mid_start && c == 10) begin
        start = 1'b1; a = 32'd0; b = 32'd1; signed_div = 1'b0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, " run_cycles_busy_no_ready"}, bad, 0);
    check({tag, " ready"}, {31'd0, ready}, 32'd1);
    check({tag, " hilo_we"}, {30'd0, hilo_we}, 32'd3);
    check({tag, " stall_done"}, {31'd0, stall}, 32'd0);
    check({tag, " lo"}, lo, elo);
    check({tag, " hi"}, hi, ehi);
    if (annul_done) begin
      annul = 1'b1;
      #1;
      check({tag, " ready_despite_annul"}, {31'd0, ready}, 32'd1);
    end
    tick();
    annul = 1'b0;
    check({tag, " ready_one_cycle"}, {31'd0, ready}, 32'd0);
    check({tag, " hilo_we_clear"}, {30'd0, hilo_we}, 32'd0);
    check({tag, " lo_hold"}, lo, elo);
    check({tag, " hi_hold"}, hi, ehi);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset hilo_we", {30'd0, hilo_we}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    // annul beats start in IDLE
    a = 32'd9; b = 32'd3; start = 1'b1; annul = 1'b1;
    #1;
    check("idle_annul stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; annul = 1'b0;
    #1;
    check("idle_annul not_started", {31'd0, stall}, 32'd0);
    tick();

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1, 1'b0);
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div("divu_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    do_div("div_by0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
    do_div("div_by0_neg", 32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b0);
    do_div("divu_by0", 32'h8000_0001, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
    do_div("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_div("div_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
    do_div("divu_big_16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
    do_div("divu_5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0);

    // annul during cycle 10 of a run; prior result (0, 5) must survive
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    annul = 1'b1;
    #1;
    check("annul stall_in_cycle10", {31'd0, stall}, 32'd1);
    tick();
    annul = 1'b0;
    check("annul stall_cycle11", {31'd0, stall}, 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (ready !== 1'b0 || stall !== 1'b0) seen++;
      tick();
    end
    check("annul no_ready_idle", seen, 0);
    check("annul lo_kept", lo, 32'd0);
    check("annul hi_kept", hi, 32'd5);
    do_div("after_annul", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 1'b0);

    // reset in cycle 20 discards the run and clears outputs
    a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid stall", {31'd0, stall}, 32'd0);
    check("rst_mid ready", {31'd0, ready}, 32'd0);
    check("rst_mid hilo_we", {30'd0, hilo_we}, 32'd0);
    check("rst_mid hi", hi, 32'd0);
    check("rst_mid lo", lo, 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (ready !== 1'b0) seen++;
      tick();
    end
    check("rst_mid no_ready", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
